seg_capture: RTL and testbench

- Receive-side counterpart of the hex-to-seven-segment decoder.
- Snoops a time-multiplexed 8-digit display bus (active-low anodes, active-low segments) and debounces each digit's dwell.
- Decodes each segment pattern back to a hex nibble and assembles the 32-bit displayed value.
- Used for board self-test and loopback checking of the CPU's display path.

---
 rtl/seg_capture.sv | 169 ++++++++++++++++
 tb/tb_seg_capture.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// seg_capture: snoops a multiplexed 8-digit seven-segment bus (active-low
// anodes and segments), debounces each digit dwell, decodes the segment
// pattern back to a hex nibble and assembles the displayed 32-bit value.
module seg_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  output logic [31:0] dout,
  output logic [7:0]  blank,
  output logic        valid,
  output logic        frame_err,
  output logic        err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // True when exactly one anode is driven low.
  function automatic logic one_low(input logic [7:0] a);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'd0, ~a[i]};
    end
    return (n == 4'd1);
  endfunction

  // Index of the (single) low anode.
  function automatic logic [2:0] low_index(input logic [7:0] a);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!a[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Segment pattern to {unknown, blank, nibble}.
  function automatic logic [5:0] decode(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'b0000001: r = 6'b00_0000;
      7'b1001111: r = 6'b00_0001;
      7'b0010010: r = 6'b00_0010;
      7'b0000110: r = 6'b00_0011;
      7'b1001100: r = 6'b00_0100;
      7'b0100100: r = 6'b00_0101;
      7'b0100000: r = 6'b00_0110;
      7'b0001111: r = 6'b00_0111;
      7'b0000000: r = 6'b00_1000;
      7'b0000100: r = 6'b00_1001;
      7'b0001000: r = 6'b00_1010;
      7'b1100000: r = 6'b00_1011;
      7'b0110001: r = 6'b00_1100;
      7'b1000010: r = 6'b00_1101;
      7'b0110000: r = 6'b00_1110;
      7'b0111000: r = 6'b00_1111;
      7'b1111111: r = 6'b01_0000;
      default:    r = 6'b10_0000;
    endcase
    return r;
  endfunction

  logic [14:0]   sync1_r;
  logic [14:0]   sync2_r;
  logic [CW-1:0] cnt_r;
  logic          captured_r;
  logic [7:0]    seen_r;
  logic [31:0]   work_val_r;
  logic [7:0]    work_blank_r;
  logic          work_err_r;
  logic [TW-1:0] tcnt_r;

  logic          changed_s;
  logic          legal_next_s;
  logic          accept_s;
  logic          complete_s;
  logic          timeout_s;
  logic [2:0]    idx_s;
  logic [5:0]    dec_s;

  // The counter tracks the sample currently held in sync2_r, so a change is
  // detected between the two synchronizer stages as the new sample moves in.
  assign changed_s    = (sync1_r != sync2_r);
  assign legal_next_s = one_low(sync1_r[14:7]);
  assign idx_s        = low_index(sync2_r[14:7]);
  assign dec_s        = decode(sync2_r[6:0]);
  assign accept_s     = one_low(sync2_r[14:7]) && (cnt_r == CW'(STABLE_CYCLES)) && !captured_r;
  assign complete_s   = (seen_r == 8'hFF);
  assign timeout_s    = (seen_r != 8'h00) && (tcnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronizer, stability counter and once-per-dwell capture flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r    <= 15'd0;
      sync2_r    <= 15'd0;
      cnt_r      <= CW'(0);
      captured_r <= 1'b0;
      err        <= 1'b0;
    end else begin
      sync1_r <= {an, seg};
      sync2_r <= sync1_r;
      if (changed_s || !legal_next_s) begin
        cnt_r <= CW'(1);
      end else if (cnt_r < CW'(STABLE_CYCLES)) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (changed_s) begin
        captured_r <= 1'b0;
      end else if (accept_s) begin
        captured_r <= 1'b1;
      end else begin
        captured_r <= captured_r;
      end
      err <= accept_s && dec_s[5];
    end
  end

  // Frame assembly: working registers, seen mask, timeout and output update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_r       <= 8'h00;
      work_val_r   <= 32'd0;
      work_blank_r <= 8'h00;
      work_err_r   <= 1'b0;
      tcnt_r       <= TW'(0);
      dout         <= 32'd0;
      blank        <= 8'h00;
      frame_err    <= 1'b0;
      valid        <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (complete_s) begin
        dout       <= work_val_r;
        blank      <= work_blank_r;
        frame_err  <= work_err_r;
        valid      <= 1'b1;
        seen_r     <= 8'h00;
        work_err_r <= 1'b0;
        tcnt_r     <= TW'(0);
      end else if (accept_s) begin
        work_val_r[{idx_s, 2'b00} +: 4] <= dec_s[3:0];
        work_blank_r[idx_s]             <= dec_s[4];
        work_err_r                      <= work_err_r | dec_s[5];
        seen_r[idx_s]                   <= 1'b1;
        tcnt_r                          <= TW'(0);
      end else if (timeout_s) begin
        seen_r     <= 8'h00;
        work_err_r <= 1'b0;
        tcnt_r     <= TW'(0);
      end else if (seen_r != 8'h00) begin
        tcnt_r <= tcnt_r + TW'(1);
      end else begin
        tcnt_r <= tcnt_r;
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Directed testbench for seg_capture with STABLE_CYCLES=4, TIMEOUT_CYCLES=50.
module tb_seg_capture;

  logic        clk;
  logic        rst_n;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [31:0] dout;
  logic [7:0]  blank;
  logic        valid;
  logic        frame_err;
  logic        err;

  int checks;
  int fails;
  int valid_cnt;
  int err_cnt;

  seg_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .dout(dout),
    .blank(blank), .valid(valid), .frame_err(frame_err), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count output pulses away from the active edge.
  always @(negedge clk) begin
    if (valid) valid_cnt = valid_cnt + 1;
    if (err) err_cnt = err_cnt + 1;
  end

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      an = 8'hFF;
      seg = 7'h7F;
    end
  endtask

  // Scan digits lo..hi, 20-cycle dwell each; optional blank/bad digits and a
  // 3-cycle glitch in the middle of one digit's dwell.
  task automatic scan(input logic [31:0] val, input int lo, input int hi,
                      input logic [7:0] blank_mask, input logic [7:0] bad_mask,
                      input int glitch_digit);
    logic [7:0] sel;
    for (int d = lo; d <= hi; d++) begin
      sel = 8'h01 << d;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        an = ~sel;
        if (blank_mask[d])               seg = 7'b1111111;
        else if (bad_mask[d])            seg = 7'b1010101;
        else                             seg = seg_of(val[d*4 +: 4]);
        if (d == glitch_digit && c >= 8 && c <= 10) seg = 7'b1111110;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    an = 8'hFF;
    seg = 7'h7F;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks = checks + 5;
    if (dout !== 32'd0)     begin fails++; $display("FAIL reset_dout got %h exp %h", dout, 32'd0); end
    if (blank !== 8'h00)    begin fails++; $display("FAIL reset_blank got %h exp %h", blank, 8'h00); end
    if (valid !== 1'b0)     begin fails++; $display("FAIL reset_valid got %b exp 0", valid); end
    if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    if (err !== 1'b0)       begin fails++; $display("FAIL reset_err got %b exp 0", err); end
  endtask

  task automatic test_basic();
    valid_cnt = 0; err_cnt = 0;
    scan(32'h1234ABCD, 0, 7, 8'h00, 8'h00, -1);
    idle(10);
    checks = checks + 5;
    if (valid_cnt !== 1)          begin fails++; $display("FAIL basic_valid_count got %0d exp 1", valid_cnt); end
    if (dout !== 32'h1234ABCD)    begin fails++; $display("FAIL basic_dout got %h exp 1234abcd", dout); end
    if (blank !== 8'h00)          begin fails++; $display("FAIL basic_blank got %h exp 00", blank); end
    if (frame_err !== 1'b0)       begin fails++; $display("FAIL basic_frame_err got %b exp 0", frame_err); end
    if (err_cnt !== 0)            begin fails++; $display("FAIL basic_err_count got %0d exp 0", err_cnt); end
  endtask

  task automatic test_glitch();
    valid_cnt = 0; err_cnt = 0;
    scan(32'h1234ABCD, 0, 7, 8'h00, 8'h00, 2);
    idle(10);
    checks = checks + 4;
    if (valid_cnt !== 1)          begin fails++; $display("FAIL glitch_valid_count got %0d exp 1", valid_cnt); end
    if (dout !== 32'h1234ABCD)    begin fails++; $display("FAIL glitch_dout got %h exp 1234abcd", dout); end
    if (frame_err !== 1'b0)       begin fails++; $display("FAIL glitch_frame_err got %b exp 0", frame_err); end
    if (err_cnt !== 0)            begin fails++; $display("FAIL glitch_err_count got %0d exp 0", err_cnt); end
  endtask

  task automatic test_unknown();
    valid_cnt = 0; err_cnt = 0;
    scan(32'h1234ABCD, 0, 7, 8'h00, 8'h20, -1);
    idle(10);
    checks = checks + 4;
    if (err_cnt !== 1)            begin fails++; $display("FAIL unknown_err_count got %0d exp 1", err_cnt); end
    if (valid_cnt !== 1)          begin fails++; $display("FAIL unknown_valid_count got %0d exp 1", valid_cnt); end
    if (frame_err !== 1'b1)       begin fails++; $display("FAIL unknown_frame_err got %b exp 1", frame_err); end
    if (dout !== 32'h1204ABCD)    begin fails++; $display("FAIL unknown_dout got %h exp 1204abcd", dout); end
    valid_cnt = 0;
    scan(32'h1234ABCD, 0, 7, 8'h00, 8'h00, -1);
    idle(10);
    checks = checks + 3;
    if (valid_cnt !== 1)          begin fails++; $display("FAIL clean_valid_count got %0d exp 1", valid_cnt); end
    if (frame_err !== 1'b0)       begin fails++; $display("FAIL clean_frame_err got %b exp 0", frame_err); end
    if (dout !== 32'h1234ABCD)    begin fails++; $display("FAIL clean_dout got %h exp 1234abcd", dout); end
  endtask

  task automatic test_blank();
    valid_cnt = 0;
    scan(32'h0000FFFF, 0, 7, 8'h80, 8'h00, -1);
    idle(10);
    checks = checks + 3;
    if (valid_cnt !== 1)          begin fails++; $display("FAIL blank_valid_count got %0d exp 1", valid_cnt); end
    if (dout !== 32'h0000FFFF)    begin fails++; $display("FAIL blank_dout got %h exp 0000ffff", dout); end
    if (blank !== 8'h80)          begin fails++; $display("FAIL blank_mask got %h exp 80", blank); end
  endtask

  task automatic test_timeout();
    valid_cnt = 0;
    scan(32'h89ABCDEF, 0, 5, 8'h00, 8'h00, -1);
    idle(80);
    checks = checks + 1;
    if (valid_cnt !== 0)          begin fails++; $display("FAIL timeout_partial_valid got %0d exp 0", valid_cnt); end
    scan(32'h89ABCDEF, 6, 7, 8'h00, 8'h00, -1);
    idle(80);
    checks = checks + 1;
    if (valid_cnt !== 0)          begin fails++; $display("FAIL timeout_tail_valid got %0d exp 0", valid_cnt); end
    scan(32'h89ABCDEF, 0, 7, 8'h00, 8'h00, -1);
    idle(10);
    checks = checks + 3;
    if (valid_cnt !== 1)          begin fails++; $display("FAIL timeout_full_valid got %0d exp 1", valid_cnt); end
    if (dout !== 32'h89ABCDEF)    begin fails++; $display("FAIL timeout_full_dout got %h exp 89abcdef", dout); end
    if (blank !== 8'h00)          begin fails++; $display("FAIL timeout_full_blank got %h exp 00", blank); end
  endtask

  task automatic test_illegal_and_reset();
    valid_cnt = 0; err_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      an = 8'b11110011;
      seg = 7'b0000110;
    end
    idle(5);
    checks = checks + 2;
    if (valid_cnt !== 0)          begin fails++; $display("FAIL illegal_valid got %0d exp 0", valid_cnt); end
    if (err_cnt !== 0)            begin fails++; $display("FAIL illegal_err got %0d exp 0", err_cnt); end
    scan(32'h76543210, 0, 3, 8'h00, 8'h00, -1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks = checks + 4;
    if (dout !== 32'd0)           begin fails++; $display("FAIL midreset_dout got %h exp 0", dout); end
    if (blank !== 8'h00)          begin fails++; $display("FAIL midreset_blank got %h exp 00", blank); end
    if (frame_err !== 1'b0)       begin fails++; $display("FAIL midreset_frame_err got %b exp 0", frame_err); end
    if (valid !== 1'b0)           begin fails++; $display("FAIL midreset_valid got %b exp 0", valid); end
    scan(32'h76543210, 4, 7, 8'h00, 8'h00, -1);
    idle(10);
    checks = checks + 1;
    if (valid_cnt !== 0)          begin fails++; $display("FAIL midreset_seen_cleared valid got %0d exp 0", valid_cnt); end
  endtask

  initial begin
    checks = 0; fails = 0; valid_cnt = 0; err_cnt = 0;
    rst_n = 1'b0; an = 8'hFF; seg = 7'h7F;
    test_reset();
    test_basic();
    test_glitch();
    test_unknown();
    test_blank();
    test_timeout();
    test_illegal_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
